tlb_maint_ctrl: RTL and testbench

- Sequencer that executes the CP0 TLB maintenance instructions TLBR, TLBWI, TLBWR and TLBP against the single maintenance port of the TLB entry array.
- Stalls the pipeline while an operation runs.
- Maintains the Random register and returns results as hardware write data and pulses for the CP0 Index, EntryHi, EntryLo0/1 and PageMask registers.
- Sits between CP0 (the operation decode and register file) and the TLB entry RAM.

---
 rtl/tlb_pkg.sv | 39 +++
 rtl/tlb_entry_match.sv | 30 +++
 rtl/tlb_maint_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_tlb_maint_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// rtl/tlb_pkg.sv - shared encodings, states and field positions for the TLB maintenance path
package tlb_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_TLBR  = 2'b01;
  localparam logic [1:0] OP_TLBWI = 2'b10;
  localparam logic [1:0] OP_TLBWR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RDCAP,
    S_WR,
    S_PROBE,
    S_DONE,
    S_HOLD
  } state_t;

  // CP0 register field positions
  localparam int VPN2_HI  = 31;
  localparam int VPN2_LO  = 13;
  localparam int MASK_HI  = 28;
  localparam int MASK_LO  = 13;
  localparam int G_BIT    = 0;
  localparam int P_BIT    = 31;

  // 128-bit entry layout: {PageMask, EntryHi, EntryLo1, EntryLo0}
  localparam int LO0_OFF  = 0;
  localparam int LO1_OFF  = 32;
  localparam int HI_OFF   = 64;
  localparam int MASK_OFF = 96;

  localparam logic [31:0]  VPN2_KEEP  = 32'hFFFF_E000;
  localparam logic [31:0]  MASK_KEEP  = 32'h1FFF_E000;
  localparam logic [31:0]  HI_WR_KEEP = 32'hFFFF_E0FF;
  localparam logic [31:0]  INDEX_P    = 32'h8000_0000;
  localparam logic [127:0] RD_KEEP    = {MASK_KEEP, HI_WR_KEEP, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

endpackage

// File: rtl/tlb_entry_match.sv
// rtl/tlb_entry_match.sv - combinational VPN2/ASID/global compare of one TLB entry against EntryHi
module tlb_entry_match
  import tlb_pkg::*;
#(
  parameter int ASID_W = 8
) (
  input  logic [127:0] entry,
  input  logic [31:0]  entry_hi,
  output logic         match
);

  logic [31:0] e_hi;
  logic [31:0] e_mask;
  logic        vpn_eq;
  logic        global_bit;
  logic        asid_eq;
  logic        unused_lo_bits;

  assign e_hi   = entry[HI_OFF +: 32];
  assign e_mask = entry[MASK_OFF +: 32];

  // PageMask bits widen the page, so those VPN2 bits drop out of the compare
  assign vpn_eq     = (((e_hi ^ entry_hi) & VPN2_KEEP & ~(e_mask & MASK_KEEP)) == 32'h0);
  assign global_bit = entry[LO0_OFF + G_BIT] & entry[LO1_OFF + G_BIT];
  assign asid_eq    = (e_hi[ASID_W-1:0] == entry_hi[ASID_W-1:0]);
  assign match      = vpn_eq && (global_bit || asid_eq);

  assign unused_lo_bits = ^{entry[LO1_OFF+1 +: 31], entry[LO0_OFF+1 +: 31]};

endmodule

// File: rtl/tlb_maint_ctrl.sv
// rtl/tlb_maint_ctrl.sv - TLBR/TLBWI/TLBWR/TLBP sequencer with Random register
// Optional: define TLB_MULTIHIT_DETECT_EN for full-scan probes with multiHit reporting.
module tlb_maint_ctrl
  import tlb_pkg::*;
#(
  parameter int ENTRIES = 32,
  parameter int IDX_W   = 5,
  parameter int ASID_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       tlbOp,
  input  logic             tlbProbe,
  input  logic [31:0]      regIndex,
  input  logic [31:0]      regEntryHi,
  input  logic [31:0]      regEntryLo0,
  input  logic [31:0]      regEntryLo1,
  input  logic [31:0]      regPageMask,
  input  logic [IDX_W-1:0] wired,
  input  logic             wiredWrite,
  output logic [IDX_W-1:0] random,
  output logic             busy,
  output logic [IDX_W-1:0] entAddr,
  output logic             entWe,
  output logic [127:0]     entWdata,
  input  logic [127:0]     entRdata,
  output logic [127:0]     resEntry,
  output logic [31:0]      resIndex,
  output logic             tlbrDone,
  output logic             tlbpDone,
  output logic             multiHit
);

  localparam logic [IDX_W-1:0] RAND_TOP  = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W:0]   K_LAST    = (IDX_W+1)'(ENTRIES);

  state_t           state, state_n;
  logic             accept;
  logic             is_read, is_probe;
  logic [IDX_W-1:0] index_q;
  logic [127:0]     opnd_q;
  logic [IDX_W:0]   k_q;
  logic [IDX_W-1:0] random_n;
  logic             match, hit, last_cmp, probe_end;
  logic [IDX_W-1:0] hit_idx;
  logic [31:0]      probe_res;
  logic             wr_g;
  logic             unused_idx_bits;

`ifdef TLB_MULTIHIT_DETECT_EN
  logic             found_q, found_n;
  logic             multi_q, multi_n;
  logic [IDX_W-1:0] first_q, first_n;
`endif

  tlb_entry_match #(.ASID_W(ASID_W)) u_match (
    .entry    (entRdata),
    .entry_hi (opnd_q[HI_OFF +: 32]),
    .match    (match)
  );

  assign unused_idx_bits = ^regIndex[31:IDX_W];

  always_comb begin
    random_n = random - IDX_W'(1);
    if (wiredWrite || (random <= wired)) begin
      random_n = RAND_TOP;
    end
  end

  // Data on entRdata during probe count k belongs to entry k-1
  always_comb begin
    hit      = (state == S_PROBE) && (k_q != '0) && match;
    hit_idx  = k_q[IDX_W-1:0] - IDX_W'(1);
    last_cmp = (k_q == K_LAST);
`ifdef TLB_MULTIHIT_DETECT_EN
    found_n   = found_q | hit;
    first_n   = found_q ? first_q : hit_idx;
    multi_n   = multi_q | (found_q & hit);
    probe_end = last_cmp;
    probe_res = found_n ? {{(32-IDX_W){1'b0}}, first_n} : INDEX_P;
`else
    probe_end = hit || last_cmp;
    probe_res = hit ? {{(32-IDX_W){1'b0}}, hit_idx} : INDEX_P;
`endif
  end

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    busy    = 1'b0;
    entWe   = 1'b0;
    entAddr = '0;
    case (state)
      S_IDLE: begin
        if (tlbProbe || (tlbOp != OP_NONE)) begin
          accept = 1'b1;
          busy   = 1'b1;
          if (tlbProbe)             state_n = S_PROBE;
          else if (tlbOp == OP_TLBR) state_n = S_RD;
          else                       state_n = S_WR;
        end
      end
      S_RD: begin
        busy    = 1'b1;
        entAddr = index_q;
        state_n = S_RDCAP;
      end
      S_RDCAP: begin
        busy    = 1'b1;
        state_n = S_DONE;
      end
      S_WR: begin
        busy    = 1'b1;
        entWe   = 1'b1;
        entAddr = index_q;
        state_n = S_DONE;
      end
      S_PROBE: begin
        busy    = 1'b1;
        entAddr = k_q[IDX_W-1:0];
        if (probe_end) state_n = S_DONE;
      end
      S_DONE:  state_n = stall ? S_HOLD : S_IDLE;
      S_HOLD:  if (!stall) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  assign wr_g     = opnd_q[LO0_OFF + G_BIT] & opnd_q[LO1_OFF + G_BIT];
  assign entWdata = {opnd_q[MASK_OFF +: 32], opnd_q[HI_OFF +: 32] & HI_WR_KEEP,
                     opnd_q[LO1_OFF+1 +: 31], wr_g, opnd_q[LO0_OFF+1 +: 31], wr_g};

  assign tlbrDone = (state == S_DONE) && is_read;
  assign tlbpDone = (state == S_DONE) && is_probe;
`ifdef TLB_MULTIHIT_DETECT_EN
  assign multiHit = (state == S_DONE) && is_probe && multi_q;
`else
  assign multiHit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      random   <= RAND_TOP;
      is_read  <= 1'b0;
      is_probe <= 1'b0;
      index_q  <= '0;
      opnd_q   <= '0;
      k_q      <= '0;
      resEntry <= '0;
      resIndex <= '0;
`ifdef TLB_MULTIHIT_DETECT_EN
      found_q  <= 1'b0;
      multi_q  <= 1'b0;
      first_q  <= '0;
`endif
    end else begin
      state  <= state_n;
      random <= random_n;
      if (accept) begin
        is_read  <= !tlbProbe && (tlbOp == OP_TLBR);
        is_probe <= tlbProbe;
        index_q  <= (tlbOp == OP_TLBWR) ? random : regIndex[IDX_W-1:0];
        opnd_q   <= {regPageMask, regEntryHi, regEntryLo1, regEntryLo0};
        k_q      <= '0;
`ifdef TLB_MULTIHIT_DETECT_EN
        found_q  <= 1'b0;
        multi_q  <= 1'b0;
`endif
      end
      if (state == S_RDCAP) begin
        resEntry <= entRdata & RD_KEEP;
      end
      if (state == S_PROBE) begin
        k_q <= k_q + (IDX_W+1)'(1);
`ifdef TLB_MULTIHIT_DETECT_EN
        found_q <= found_n;
        first_q <= first_n;
        multi_q <= multi_n;
`endif
        if (probe_end) resIndex <= probe_res;
      end
    end
  end

endmodule

// File: tb/tb_tlb_maint_ctrl.sv
// tb/tb_tlb_maint_ctrl.sv - self-checking bench for tlb_maint_ctrl (honours TLB_MULTIHIT_DETECT_EN)
module tb_tlb_maint_ctrl;

  localparam int ENTRIES = 32;
  localparam int IDX_W   = 5;
`ifdef TLB_MULTIHIT_DETECT_EN
  localparam bit MH = 1'b1;
`else
  localparam bit MH = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         stall = 1'b0;
  logic [1:0]   tlbOp = 2'b00;
  logic         tlbProbe = 1'b0;
  logic [31:0]  regIndex = '0, regEntryHi = '0, regEntryLo0 = '0, regEntryLo1 = '0, regPageMask = '0;
  logic [4:0]   wired = '0;
  logic         wiredWrite = 1'b0;
  logic [4:0]   random;
  logic         busy;
  logic [4:0]   entAddr;
  logic         entWe;
  logic [127:0] entWdata;
  logic [127:0] entRdata;
  logic [127:0] resEntry;
  logic [31:0]  resIndex;
  logic         tlbrDone, tlbpDone, multiHit;

  always #5 clk = ~clk;

  tlb_maint_ctrl #(.ENTRIES(ENTRIES), .IDX_W(IDX_W), .ASID_W(8)) dut (
    .clk(clk), .rst(rst), .stall(stall), .tlbOp(tlbOp), .tlbProbe(tlbProbe),
    .regIndex(regIndex), .regEntryHi(regEntryHi), .regEntryLo0(regEntryLo0),
    .regEntryLo1(regEntryLo1), .regPageMask(regPageMask), .wired(wired),
    .wiredWrite(wiredWrite), .random(random), .busy(busy), .entAddr(entAddr),
    .entWe(entWe), .entWdata(entWdata), .entRdata(entRdata), .resEntry(resEntry),
    .resIndex(resIndex), .tlbrDone(tlbrDone), .tlbpDone(tlbpDone), .multiHit(multiHit)
  );

  // Entry RAM with one-cycle read latency and a write log
  logic [127:0] ram [ENTRIES];
  logic         ram_clr = 1'b1;
  int           wr_count;
  logic [4:0]   wr_addr;
  logic [127:0] wr_data;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < ENTRIES; i++) ram[i] <= '0;
      wr_count <= 0;
      wr_addr  <= '0;
      wr_data  <= '0;
    end else if (entWe) begin
      ram[entAddr] <= entWdata;
      wr_count     <= wr_count + 1;
      wr_addr      <= entAddr;
      wr_data      <= entWdata;
    end
    entRdata <= ram[entAddr];
  end

  // Random register reference: reload to the top on wired write or at/below wired
  int model_rand;
  always @(posedge clk or posedge rst) begin
    if (rst) model_rand <= ENTRIES - 1;
    else if (wiredWrite || model_rand <= int'(wired)) model_rand <= ENTRIES - 1;
    else model_rand <= model_rand - 1;
  end

  logic [127:0] ref_mem [ENTRIES];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("random track", 128'(random), 128'(model_rand));
  endtask

  function automatic bit model_match(input logic [127:0] e, input logic [31:0] h);
    logic [31:0] ehi, emask;
    bit ok;
    ehi = e[95:64];
    emask = e[127:96];
    ok = 1'b1;
    for (int b = 13; b < 32; b++)
      if (ehi[b] != h[b] && !(b <= 28 && emask[b])) ok = 1'b0;
    return ok && ((e[0] && e[32]) || ehi[7:0] == h[7:0]);
  endfunction

  function automatic logic [127:0] wr_xform(input logic [31:0] pm, hi, lo1, lo0);
    logic g;
    g = lo0[0] & lo1[0];
    return {pm, hi & 32'hFFFF_E0FF, lo1[31:1], g, lo0[31:1], g};
  endfunction

  function automatic logic [127:0] rd_xform(input logic [127:0] e);
    return {e[127:96] & 32'h1FFF_E000, e[95:64] & 32'hFFFF_E0FF, e[63:0]};
  endfunction

  task automatic do_op(input logic [1:0] op, input bit pr, input logic [31:0] idx, hi, lo0, lo1, pm,
                       output int cyc, output bit rp, output bit pp, output bit mh,
                       output int acc_rand, output int nwr);
    int wc0;
    step();
    tlbOp = op; tlbProbe = pr; regIndex = idx; regEntryHi = hi;
    regEntryLo0 = lo0; regEntryLo1 = lo1; regPageMask = pm;
    acc_rand = model_rand;
    wc0 = wr_count;
    #1;
    cyc = 0;
    while (busy && cyc < 100) begin
      cyc++;
      step();
      tlbOp = 2'b00;
      tlbProbe = 1'b0;
      #1;
    end
    rp = tlbrDone; pp = tlbpDone; mh = multiHit;
    nwr = wr_count - wc0;
  endtask

  typedef struct {
    logic [1:0]   op;
    logic         probe;
    logic [31:0]  idx, hi, lo0, lo1, pm;
    int           cyc;
    logic         rp, pp;
    logic [127:0] res;
  } vec_t;

  vec_t vt [6];

  initial begin
    int cyc, acc, nwr, n, first, nm, kind, e, exp_cyc;
    bit rp, pp, mh;
    logic [31:0] hi, lo0, lo1, pm, idx, exp_idx;
    logic [4:0]  tgt;
    logic [127:0] exp_e;

    vt[0] = '{2'b10, 1'b0, 32'd5, 32'h0040_20FF, 32'h11, 32'h20, 32'h0, 2, 1'b0, 1'b0,
              {32'h0, 32'h0040_20FF, 32'h20, 32'h10}};
    vt[1] = '{2'b01, 1'b0, 32'd5, 32'h0, 32'h0, 32'h0, 32'h0, 3, 1'b1, 1'b0,
              {32'h0, 32'h0040_20FF, 32'h20, 32'h10}};
    vt[2] = '{2'b00, 1'b1, 32'd0, 32'h0040_20FF, 32'h0, 32'h0, 32'h0, MH ? 34 : 8, 1'b0, 1'b1,
              128'h5};
    vt[3] = '{2'b01, 1'b1, 32'd5, 32'h0040_2001, 32'h0, 32'h0, 32'h0, 34, 1'b0, 1'b1,
              128'h8000_0000};
    vt[4] = '{2'b10, 1'b0, 32'hFFFF_FFE7, 32'h1234_5FAB, 32'h3, 32'h5, 32'hFFFF_FFFF, 2, 1'b0, 1'b0,
              {32'hFFFF_FFFF, 32'h1234_40AB, 32'h5, 32'h3}};
    vt[5] = '{2'b01, 1'b0, 32'd7, 32'h0, 32'h0, 32'h0, 32'h0, 3, 1'b1, 1'b0,
              {32'h1FFF_E000, 32'h1234_40AB, 32'h5, 32'h3}};
    for (int i = 0; i < ENTRIES; i++) ref_mem[i] = '0;

    #1 rst = 1'b1;
    repeat (2) step();
    #1;
    check("rst busy", 128'(busy), 128'(0));
    check("rst entWe", 128'(entWe), 128'(0));
    check("rst entAddr", 128'(entAddr), 128'(0));
    check("rst resEntry", resEntry, 128'(0));
    check("rst resIndex", 128'(resIndex), 128'(0));
    check("rst random", 128'(random), 128'(31));
    check("rst pulses", 128'({tlbrDone, tlbpDone, multiHit}), 128'(0));
    rst = 1'b0;
    ram_clr = 1'b0;

    for (int i = 0; i < 5; i++) begin
      if (i != 0) step();
      #1;
      check($sformatf("idle random %0d", i), 128'(random), 128'(31 - i));
    end

    wired = 5'd3;
    n = 0;
    while (random != 5'd3 && n < 40) begin step(); n++; end
    check("random reached wired", 128'(random), 128'(3));
    step();
    check("random reload at wired", 128'(random), 128'(31));
    step();
    step();
    wiredWrite = 1'b1;
    step();
    wiredWrite = 1'b0;
    check("random reload on wiredWrite", 128'(random), 128'(31));
    wired = 5'd0;

    for (int i = 0; i < 6; i++) begin
      do_op(vt[i].op, vt[i].probe, vt[i].idx, vt[i].hi, vt[i].lo0, vt[i].lo1, vt[i].pm,
            cyc, rp, pp, mh, acc, nwr);
      check($sformatf("vec%0d busy cycles", i), 128'(cyc), 128'(vt[i].cyc));
      check($sformatf("vec%0d tlbrDone", i), 128'(rp), 128'(vt[i].rp));
      check($sformatf("vec%0d tlbpDone", i), 128'(pp), 128'(vt[i].pp));
      if (vt[i].probe) begin
        check($sformatf("vec%0d resIndex", i), 128'(resIndex), 128'(vt[i].res[31:0]));
        check($sformatf("vec%0d writes", i), 128'(nwr), 128'(0));
      end else if (vt[i].op == 2'b01) begin
        check($sformatf("vec%0d resEntry", i), resEntry, vt[i].res);
        check($sformatf("vec%0d writes", i), 128'(nwr), 128'(0));
      end else begin
        check($sformatf("vec%0d writes", i), 128'(nwr), 128'(1));
        check($sformatf("vec%0d wr addr", i), 128'(wr_addr), 128'(vt[i].idx[4:0]));
        check($sformatf("vec%0d wr data", i), wr_data, vt[i].res);
        ref_mem[vt[i].idx[4:0]] = vt[i].res;
      end
    end

    // Stale TLBR held across DONE by stall must not re-execute
    step();
    tlbOp = 2'b01; regIndex = 32'd5; stall = 1'b1;
    #1;
    n = 0;
    while (busy && n < 10) begin n++; step(); #1; end
    check("hold first busy", 128'(n), 128'(3));
    check("hold first tlbrDone", 128'(tlbrDone), 128'(1));
    for (int i = 0; i < 4; i++) begin
      step();
      #1;
      check($sformatf("hold busy %0d", i), 128'(busy), 128'(0));
      check($sformatf("hold tlbrDone %0d", i), 128'(tlbrDone), 128'(0));
    end
    step();
    stall = 1'b0;
    tlbOp = 2'b00;
    #1;
    check("hold release busy", 128'(busy), 128'(0));
    do_op(2'b10, 1'b0, 32'd2, 32'h00AB_0000, 32'h1, 32'h1, 32'h0, cyc, rp, pp, mh, acc, nwr);
    check("post-hold write cycles", 128'(cyc), 128'(2));
    check("post-hold write data", wr_data, wr_xform(32'h0, 32'h00AB_0000, 32'h1, 32'h1));
    ref_mem[2] = wr_xform(32'h0, 32'h00AB_0000, 32'h1, 32'h1);
    do_op(2'b10, 1'b0, 32'd9, 32'h00AB_0000, 32'h1, 32'h1, 32'h0, cyc, rp, pp, mh, acc, nwr);
    ref_mem[9] = wr_xform(32'h0, 32'h00AB_0000, 32'h1, 32'h1);
    check("entry9 write addr", 128'(wr_addr), 128'(9));

    do_op(2'b00, 1'b1, 32'd0, 32'h00AB_0000, 32'h0, 32'h0, 32'h0, cyc, rp, pp, mh, acc, nwr);
    check("multi probe resIndex", 128'(resIndex), 128'(2));
    check("multi probe cycles", 128'(cyc), 128'(MH ? 34 : 5));
    check("multi probe multiHit", 128'(mh), 128'(MH));

    // Reset while the probe counter is at 10
    step();
    tlbProbe = 1'b1; regEntryHi = 32'hE040_2001;
    step();
    tlbProbe = 1'b0;
    repeat (10) step();
    #1;
    check("probe busy before rst", 128'(busy), 128'(1));
    check("probe addr before rst", 128'(entAddr), 128'(10));
    rst = 1'b1;
    #1;
    check("mid-probe rst busy", 128'(busy), 128'(0));
    check("mid-probe rst entWe", 128'(entWe), 128'(0));
    check("mid-probe rst entAddr", 128'(entAddr), 128'(0));
    check("mid-probe rst resIndex", 128'(resIndex), 128'(0));
    step();
    rst = 1'b0;

    for (int it = 0; it < 64; it++) begin
      kind = it % 4;
      wired = 5'($urandom_range(0, 6));
      e = $urandom_range(0, ENTRIES - 1);
      hi = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        hi[31:13] = ref_mem[e][95:77];
        if ($urandom_range(0, 1) != 0) hi[7:0] = ref_mem[e][71:64];
      end
      lo0 = $urandom;
      lo1 = $urandom;
      pm = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      idx = $urandom;
      case (kind)
        0: begin
          do_op(2'b01, 1'b0, idx, hi, lo0, lo1, pm, cyc, rp, pp, mh, acc, nwr);
          check("rnd TLBR cycles", 128'(cyc), 128'(3));
          check("rnd TLBR done", 128'({rp, pp}), 128'(2));
          check("rnd TLBR resEntry", resEntry, rd_xform(ref_mem[idx[4:0]]));
        end
        1, 2: begin
          do_op((kind == 1) ? 2'b10 : 2'b11, 1'b0, idx, hi, lo0, lo1, pm, cyc, rp, pp, mh, acc, nwr);
          tgt = (kind == 1) ? idx[4:0] : 5'(acc);
          exp_e = wr_xform(pm, hi, lo1, lo0);
          check("rnd write cycles", 128'(cyc), 128'(2));
          check("rnd write count", 128'(nwr), 128'(1));
          check("rnd write addr", 128'(wr_addr), 128'(tgt));
          check("rnd write data", wr_data, exp_e);
          ref_mem[tgt] = exp_e;
        end
        default: begin
          first = -1;
          nm = 0;
          for (int j = 0; j < ENTRIES; j++)
            if (model_match(ref_mem[j], hi)) begin
              nm++;
              if (first < 0) first = j;
            end
          exp_cyc = (MH || first < 0) ? 34 : first + 3;
          exp_idx = (first < 0) ? 32'h8000_0000 : 32'(first);
          do_op(2'b00, 1'b1, idx, hi, lo0, lo1, pm, cyc, rp, pp, mh, acc, nwr);
          check("rnd TLBP cycles", 128'(cyc), 128'(exp_cyc));
          check("rnd TLBP resIndex", 128'(resIndex), 128'(exp_idx));
          check("rnd TLBP done", 128'({rp, pp}), 128'(1));
          check("rnd TLBP multiHit", 128'(mh), 128'(MH && nm >= 2));
        end
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

endmodule
